// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm setting controller.
// Holds the FSM encoding, BCD time limits, the default snooze length and an hour-increment helper.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_T_HR    = 3'd1,
    ST_T_MIN   = 3'd2,
    ST_T_LD    = 3'd3,
    ST_A_HR    = 3'd4,
    ST_A_MIN   = 3'd5,
    ST_A_LD    = 3'd6,
    ST_SNZ_ADD = 3'd7
  } state_e;

  localparam int unsigned HOUR_MAX           = 23;
  localparam int unsigned MIN_MAX            = 59;
  localparam int unsigned SNOOZE_MIN_DEFAULT = 5;
  localparam int unsigned CNT_W              = 6;
  localparam int unsigned HHMM_W             = 14;

  localparam logic [1:0] HR_TENS_MAX  = 2'(HOUR_MAX / 10);
  localparam logic [3:0] HR_ONES_MAX  = 4'(HOUR_MAX % 10);
  localparam logic [3:0] MIN_TENS_MAX = 4'(MIN_MAX / 10);
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // BCD hh:mm, tens digit of hours only needs two bits
  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  // Hours +1 with 23 -> 00 wrap; minutes pass through untouched
  function automatic hhmm_t hour_inc(input hhmm_t t);
    hhmm_t r;
    r = t;
    if ((t.h1 == HR_TENS_MAX) && (t.h0 == HR_ONES_MAX)) begin
      r.h1 = 2'd0;
      r.h0 = 4'd0;
    end else if (t.h0 == DIGIT_MAX) begin
      r.h1 = t.h1 + 2'd1;
      r.h0 = 4'd0;
    end else begin
      r.h0 = t.h0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_min_inc.sv
// Combinational BCD hh:mm plus one minute, carrying into the hour and wrapping 23:59 -> 00:00.
module bcd_min_inc
  import alarm_pkg::*;
(
  input  logic [HHMM_W-1:0] i_time,
  output logic [HHMM_W-1:0] o_time_c
);

  hhmm_t w_in;
  hhmm_t w_hr_up;
  hhmm_t w_out;

  assign w_in    = i_time;
  assign w_hr_up = hour_inc(w_in);

  always_comb begin
    w_out = w_in;
    if (w_in.m0 != DIGIT_MAX) begin
      w_out.m0 = w_in.m0 + 4'd1;
    end else if (w_in.m1 != MIN_TENS_MAX) begin
      w_out.m0 = 4'd0;
      w_out.m1 = w_in.m1 + 4'd1;
    end else begin
      w_out.h1 = w_hr_up.h1;
      w_out.h0 = w_hr_up.h0;
      w_out.m1 = 4'd0;
      w_out.m0 = 4'd0;
    end
  end

  assign o_time_c = w_out;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Button-driven time/alarm edit sequencer with snooze for a BCD alarm clock core.
// All outputs are registered from next-state values so they line up with the state they describe.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = SNOOZE_MIN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_al,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  input  logic       alarm_in,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] SNZ_LOAD = CNT_W'(SNOOZE_MIN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            r_state;
  hhmm_t             r_tbuf;
  hhmm_t             r_abuf;
  hhmm_t             r_disp;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_al_on;
  logic              r_ld_time;
  logic              r_ld_alarm;
  logic              r_stop_al;

  state_e            w_state_nxt;
  hhmm_t             w_tbuf_nxt;
  hhmm_t             w_abuf_nxt;
  hhmm_t             w_disp_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_al_on_nxt;
  logic              w_stop_nxt;
  logic              w_ld_time_nxt;
  logic              w_ld_alarm_nxt;
  hhmm_t             w_inc_src;
  hhmm_t             w_inc_res;
  hhmm_t             w_t_hr_up;
  hhmm_t             w_a_hr_up;

  // Only T_MIN edits tbuf minutes; every other user of the adder works on abuf
  assign w_inc_src = (r_state == ST_T_MIN) ? r_tbuf : r_abuf;
  assign w_t_hr_up = hour_inc(r_tbuf);
  assign w_a_hr_up = hour_inc(r_abuf);

  bcd_min_inc u_min_inc (
    .i_time   (w_inc_src),
    .o_time_c (w_inc_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tbuf_nxt  = r_tbuf;
    w_abuf_nxt  = r_abuf;
    w_cnt_nxt   = r_cnt;
    w_al_on_nxt = r_al_on;
    w_stop_nxt  = btn_stop & alarm_in;

    case (r_state)
      ST_IDLE: begin
        if (btn_al) begin
          w_al_on_nxt = ~r_al_on;
        end
        if (btn_mode) begin
          w_state_nxt = ST_T_HR;
        end else if (btn_snooze && alarm_in) begin
          // First snooze minute is applied on entry so each SNZ_ADD cycle shows its own sum
          w_state_nxt = ST_SNZ_ADD;
          w_cnt_nxt   = SNZ_LOAD;
          w_abuf_nxt  = w_inc_res;
          w_stop_nxt  = 1'b1;
        end
      end
      ST_T_HR: begin
        if (btn_mode) begin
          w_state_nxt = ST_T_MIN;
        end else if (btn_inc) begin
          w_tbuf_nxt.h1 = w_t_hr_up.h1;
          w_tbuf_nxt.h0 = w_t_hr_up.h0;
        end
      end
      ST_T_MIN: begin
        if (btn_mode) begin
          w_state_nxt = ST_T_LD;
        end else if (btn_inc) begin
          w_tbuf_nxt.m1 = w_inc_res.m1;
          w_tbuf_nxt.m0 = w_inc_res.m0;
        end
      end
      ST_T_LD: begin
        w_state_nxt = ST_A_HR;
      end
      ST_A_HR: begin
        if (btn_mode) begin
          w_state_nxt = ST_A_MIN;
        end else if (btn_inc) begin
          w_abuf_nxt.h1 = w_a_hr_up.h1;
          w_abuf_nxt.h0 = w_a_hr_up.h0;
        end
      end
      ST_A_MIN: begin
        if (btn_mode) begin
          w_state_nxt = ST_A_LD;
        end else if (btn_inc) begin
          w_abuf_nxt.m1 = w_inc_res.m1;
          w_abuf_nxt.m0 = w_inc_res.m0;
        end
      end
      ST_A_LD: begin
        w_state_nxt = ST_IDLE;
      end
      ST_SNZ_ADD: begin
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt  = r_cnt - CNT_ONE;
          w_abuf_nxt = w_inc_res;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_ld_time_nxt  = (w_state_nxt == ST_T_LD);
  assign w_ld_alarm_nxt = (w_state_nxt == ST_A_LD) ||
                          ((w_state_nxt == ST_SNZ_ADD) && (w_cnt_nxt == CNT_ONE));
  assign w_disp_nxt     = (w_state_nxt inside {ST_T_HR, ST_T_MIN, ST_T_LD}) ? w_tbuf_nxt : w_abuf_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tbuf     <= '0;
      r_abuf     <= '0;
      r_disp     <= '0;
      r_cnt      <= '0;
      r_al_on    <= 1'b0;
      r_ld_time  <= 1'b0;
      r_ld_alarm <= 1'b0;
      r_stop_al  <= 1'b0;
    end else begin
      r_tbuf     <= w_tbuf_nxt;
      r_abuf     <= w_abuf_nxt;
      r_disp     <= w_disp_nxt;
      r_cnt      <= w_cnt_nxt;
      r_al_on    <= w_al_on_nxt;
      r_ld_time  <= w_ld_time_nxt;
      r_ld_alarm <= w_ld_alarm_nxt;
      r_stop_al  <= w_stop_nxt;
    end
  end

  assign H_in1    = r_disp.h1;
  assign H_in0    = r_disp.h0;
  assign M_in1    = r_disp.m1;
  assign M_in0    = r_disp.m0;
  assign LD_time  = r_ld_time;
  assign LD_alarm = r_ld_alarm;
  assign STOP_al  = r_stop_al;
  assign AL_ON    = r_al_on;
  assign state_o  = r_state;

endmodule
